// File: rtl/axis_gen_pkg.sv
// Shared types and helpers for the AXI-Stream generator datapath.
package axis_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    localparam int MAX_BYTES      = 128;
    localparam int DEF_DATA_BYTES = 8;
    localparam int KEEP_IDX_W     = (DEF_DATA_BYTES > 1) ? $clog2(DEF_DATA_BYTES) : 1;

    // Generalised left/right thermometer: 'count' enables packed from lane 0 or from the top
    // lane of an nbytes-wide bus; count==0 means a full beat.
    function automatic logic [MAX_BYTES-1:0] thermo_mask(input int count, input logic msb_first,
                                                         input int nbytes);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < nbytes && (count == 0 || i < count)) begin
                if (msb_first) m[7'(nbytes - 1 - i)] = 1'b1;
                else           m[7'(i)]              = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_keep_thermo.sv
// Last-beat byte-enable generator: remainder byte count to thermometer tkeep.
module axis_keep_thermo
    import axis_gen_pkg::*;
#(
    parameter int DATA_BYTES = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int KW         = 3
) (
    input  logic [KW-1:0]         rem,
    output logic [DATA_BYTES-1:0] keep
);

    assign keep = DATA_BYTES'(thermo_mask(int'(rem), MSB_FIRST, DATA_BYTES));

endmodule

// File: rtl/axis_pkt_framer.sv
// Command-driven AXI-Stream packet source: {len, seed} in, incrementing-byte payload beats out.
module axis_pkt_framer
    import axis_gen_pkg::*;
#(
    parameter int DATA_BYTES = 8,
    parameter int LEN_W      = 16,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic [7:0]              cmd_seed,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [8*DATA_BYTES-1:0] m_axis_tdata,
    output logic [DATA_BYTES-1:0]   m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    pkt_done,
    output logic                    err_zero_len
);

    localparam int              KW   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int              SH   = $clog2(DATA_BYTES);
    localparam logic [7:0]      STEP = 8'(DATA_BYTES);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] TWO = LEN_W'(2);

    fsm_state_t              state, state_nxt;
    logic [LEN_W-1:0]        beats_left, beats_init;
    logic [7:0]              offset;
    logic [DATA_BYTES-1:0]   last_keep, keep_thermo, first_keep, next_keep;
    logic [KW-1:0]           rem;
    logic                    accept, hs;

    assign accept     = cmd_valid && cmd_ready;
    assign hs         = m_axis_tvalid && m_axis_tready;
    assign rem        = KW'(cmd_len & LEN_W'(DATA_BYTES - 1));
    // Shift-and-round-up cannot overflow even at the maximum length.
    assign beats_init = (cmd_len >> SH) + LEN_W'(rem != '0);
    assign first_keep = (beats_init == ONE) ? keep_thermo : '1;
    assign next_keep  = (beats_left == TWO) ? last_keep : '1;

    axis_keep_thermo #(
        .DATA_BYTES (DATA_BYTES),
        .MSB_FIRST  (MSB_FIRST),
        .KW         (KW)
    ) u_keep (
        .rem  (rem),
        .keep (keep_thermo)
    );

    // Lanes with keep=0 are forced to zero so partial beats carry no stale bytes.
    function automatic logic [8*DATA_BYTES-1:0] beat_data(input logic [7:0] off,
                                                          input logic [DATA_BYTES-1:0] keep);
        logic [8*DATA_BYTES-1:0] d;
        int                      i;
        d = '0;
        for (int j = 0; j < DATA_BYTES; j++) begin
            i = MSB_FIRST ? (DATA_BYTES - 1 - j) : j;
            if (keep[j]) d[8*j +: 8] = off + 8'(i);
        end
        return d;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && cmd_len != '0) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (hs && m_axis_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beats_left    <= '0;
            offset        <= '0;
            last_keep     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            pkt_done      <= 1'b0;
            err_zero_len  <= 1'b0;
        end else begin
            pkt_done     <= 1'b0;
            err_zero_len <= 1'b0;
            if (accept) begin
                if (cmd_len == '0) begin
                    err_zero_len <= 1'b1;
                end else begin
                    beats_left    <= beats_init;
                    offset        <= cmd_seed;
                    last_keep     <= keep_thermo;
                    m_axis_tvalid <= 1'b1;
                    m_axis_tlast  <= (beats_init == ONE);
                    m_axis_tkeep  <= first_keep;
                    m_axis_tdata  <= beat_data(cmd_seed, first_keep);
                end
            end else if (busy && hs) begin
                if (m_axis_tlast) begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                    m_axis_tkeep  <= '0;
                    m_axis_tdata  <= '0;
                    pkt_done      <= 1'b1;
                end else begin
                    beats_left   <= beats_left - ONE;
                    offset       <= offset + STEP;
                    m_axis_tlast <= (beats_left == TWO);
                    m_axis_tkeep <= next_keep;
                    m_axis_tdata <= beat_data(offset + STEP, next_keep);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Scoreboard bench: LSB-first and MSB-first framers driven in lockstep against a byte-level model.
module tb_axis_pkt_framer;

    localparam int DB = 4;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset_n, cmd_valid, tready;
    logic [LW-1:0] cmd_len;
    logic [7:0]    cmd_seed;
    logic          cmd_ready0, tvalid0, tlast0, busy0, pkt_done0, err0;
    logic          cmd_ready1, tvalid1, tlast1, busy1, pkt_done1, err1;
    logic [8*DB-1:0] tdata0, tdata1;
    logic [DB-1:0]   tkeep0, tkeep1;

    always #5 clk = ~clk;

    axis_pkt_framer #(.DATA_BYTES(DB), .LEN_W(LW), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
        .cmd_len(cmd_len), .cmd_seed(cmd_seed), .m_axis_tvalid(tvalid0), .m_axis_tready(tready),
        .m_axis_tdata(tdata0), .m_axis_tkeep(tkeep0), .m_axis_tlast(tlast0), .busy(busy0),
        .pkt_done(pkt_done0), .err_zero_len(err0));

    axis_pkt_framer #(.DATA_BYTES(DB), .LEN_W(LW), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
        .cmd_len(cmd_len), .cmd_seed(cmd_seed), .m_axis_tvalid(tvalid1), .m_axis_tready(tready),
        .m_axis_tdata(tdata1), .m_axis_tkeep(tkeep1), .m_axis_tlast(tlast1), .busy(busy1),
        .pkt_done(pkt_done1), .err_zero_len(err1));

    typedef struct packed {
        logic [8*DB-1:0] d0, d1;
        logic [DB-1:0]   k0, k1;
        logic            last;
    } beat_t;

    beat_t q[$];
    int    total = 0, bad = 0;
    int    outstanding = 0, pkt_hs = 0, mode = 0, pat_i = 0;
    bit    err_exp = 1'b0;
    int    pat[8] = '{1, 0, 0, 1, 0, 1, 1, 1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Stream byte n of a packet is seed+n; lane placement and keep follow directly from n.
    task automatic model_push(input int len, input logic [7:0] seed);
        int    nb;
        beat_t b;
        logic [7:0] v;
        nb = (len + DB - 1) / DB;
        for (int k = 0; k < nb; k++) begin
            b = '0;
            for (int i = 0; i < DB; i++) begin
                if (k * DB + i < len) begin
                    v = seed + 8'(k * DB + i);
                    b.d0[8*i +: 8]        = v;
                    b.k0[i]               = 1'b1;
                    b.d1[8*(DB-1-i) +: 8] = v;
                    b.k1[DB-1-i]          = 1'b1;
                end
            end
            b.last = (k == nb - 1);
            q.push_back(b);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (mode)
            0: tready = 1'b1;
            1: begin tready = pat[pat_i % 8] != 0; pat_i++; end
            default: tready = ($urandom % 4) != 0;
        endcase
    end

    // Monitor: protocol, pulse timing and scoreboard pops, sampled mid-cycle.
    logic  stall = 1'b0, done_pend = 1'b0;
    logic [37:0] hold0, hold1;
    beat_t eb;
    always @(negedge clk) begin
        if (!reset_n) begin
            stall     = 1'b0;
            done_pend = 1'b0;
        end else begin
            if (pkt_done0 || pkt_done1 || done_pend)
                chk("pkt_done", {pkt_done1, pkt_done0}, {2{done_pend}});
            if (err0 || err1 || err_exp)
                chk("err_zero_len", {err1, err0}, {2{err_exp}});
            chk("busy", {busy1, busy0}, {2{outstanding != 0}});
            chk("cmd_ready", {cmd_ready1, cmd_ready0}, {2{outstanding == 0}});
            if (stall) begin
                chk("stall_hold0", {tvalid0, tdata0, tkeep0, tlast0}, hold0);
                chk("stall_hold1", {tvalid1, tdata1, tkeep1, tlast1}, hold1);
            end
            done_pend = 1'b0;
            stall     = tvalid0 && !tready;
            hold0     = {tvalid0, tdata0, tkeep0, tlast0};
            hold1     = {tvalid1, tdata1, tkeep1, tlast1};
            if (tvalid0 && tready) begin
                chk("tvalid_pair", tvalid1, 1);
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_beat: got data %h with empty scoreboard", tdata0);
                end else begin
                    eb = q.pop_front();
                    chk("beat_lsb", {tdata0, tkeep0, tlast0}, {eb.d0, eb.k0, eb.last});
                    chk("beat_msb", {tdata1, tkeep1, tlast1}, {eb.d1, eb.k1, eb.last});
                    pkt_hs++;
                    if (eb.last) begin
                        done_pend = 1'b1;
                        outstanding--;
                    end
                end
            end
        end
    end

    task automatic finish_now();
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "bench aborted");
    endtask

    task automatic wait_idle(input bit garb);
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            err_exp = 1'b0;
            if (outstanding == 0) begin
                cmd_valid = 1'b0;
                break;
            end
            if (garb) begin
                cmd_valid = ($urandom % 2) != 0;
                cmd_len   = LW'($urandom);
                cmd_seed  = 8'($urandom);
            end
            n++;
            if (n > 20000) begin
                total++; bad++;
                $display("FAIL wait_idle: timeout, %0d beats still expected", q.size());
                finish_now();
            end
        end
    endtask

    task automatic issue(input int len, input logic [7:0] seed);
        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        cmd_seed  = seed;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_len   = LW'($urandom);
        cmd_seed  = 8'($urandom);
        if (len == 0) err_exp = 1'b1;
        else begin
            model_push(len, seed);
            outstanding++;
            pkt_hs = 0;
        end
    endtask

    task automatic send(input int len, input logic [7:0] seed, input bit garb);
        wait_idle(1'b0);
        issue(len, seed);
        wait_idle(garb);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, n;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_seed = '0; tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", {cmd_ready0, cmd_ready1, tvalid0, tvalid1, busy0, busy1, tlast0, tlast1},
            8'b1100_0000);
        chk("rst_data", {tdata0, tkeep0, tdata1, tkeep1}, '0);
        chk("rst_pulses", {pkt_done0, pkt_done1, err0, err1}, '0);

        send(10, 8'h00, 1'b0);
        send(8, 8'hFE, 1'b0);
        send(1, 8'hAA, 1'b0);
        mode = 1; pat_i = 0;
        send(16, 8'($urandom), 1'b1);
        mode = 0;
        send(0, 8'h33, 1'b0);

        mode = 2;
        repeat (40) begin
            case ($urandom % 8)
                0:       len = 0;
                1:       len = $urandom_range(1, DB);
                default: len = $urandom_range(1, 48);
            endcase
            send(len, 8'($urandom), ($urandom % 2) != 0);
        end
        mode = 0;
        send(65535, 8'($urandom), 1'b0);

        // Reset one cycle after the second beat of a packet is taken.
        wait_idle(1'b0);
        issue(16, 8'h55);
        n = 0;
        while (pkt_hs < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_rst_reach", pkt_hs, 2);
        reset_n = 1'b0;
        q.delete();
        outstanding = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_tvalid", {tvalid1, tvalid0}, 2'b00);
        repeat (3) @(posedge clk);
        send(4, 8'h10, 1'b0);

        wait_idle(1'b0);
        repeat (2) @(posedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
